// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types and constants for the I2C EEPROM target
package i2c_target_pkg;

    localparam int EEPROM_ADDR_W = 11;
    localparam logic [3:0] DEV_TYPE_DEFAULT = 4'b1010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CTRL,
        ST_CTRL_ACK,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/i2c_eeprom_target_if.sv
// rtl/i2c_eeprom_target_if.sv - single-port byte memory bus between target and storage
interface i2c_eeprom_target_if;
    import i2c_target_pkg::*;

    logic [EEPROM_ADDR_W-1:0] mem_addr;
    logic [7:0]               mem_wdata;
    logic                     mem_we;
    logic                     mem_re;
    logic [7:0]               mem_rdata;

    modport master (output mem_addr, output mem_wdata, output mem_we, output mem_re,
                    input mem_rdata);
    modport slave  (input mem_addr, input mem_wdata, input mem_we, input mem_re,
                    output mem_rdata);
endinterface

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - pad synchronizer plus rise/fall detect for one I2C line
module i2c_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], pad};
        hist_d = sync_q[STAGES-1];
    end

    // Reset to the idle-high bus level so release from reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~hist_q;
    assign fall  = ~level & hist_q;
endmodule

// File: rtl/i2c_eeprom_target.sv
// rtl/i2c_eeprom_target.sv - I2C responder emulating a 2 KiB 24xx16-class EEPROM
module i2c_eeprom_target
    import i2c_target_pkg::*;
#(
    parameter logic [3:0] DEV_TYPE    = DEV_TYPE_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                scl_in,
    input  logic                sda_in,
    output logic                sda_drive_low,
    output logic                busy,
    i2c_eeprom_target_if.master mem
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .rst_n(reset_n), .pad(scl_in),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .rst_n(reset_n), .pad(sda_in),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    state_e                   state_q, state_d;
    logic [2:0]               bit_cnt_q, bit_cnt_d;
    logic [7:0]               shift_q, shift_d;
    logic [7:0]               tx_q, tx_d;
    logic [EEPROM_ADDR_W-1:0] ptr_q, ptr_d;
    logic [EEPROM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]               mem_wdata_q, mem_wdata_d;
    logic                     mem_we_q, mem_we_d, mem_re_q, mem_re_d, re_dly_q, re_dly_d;
    logic                     sda_q, sda_d, busy_q, busy_d, rd_path_q, rd_path_d;
    logic                     start_det, stop_det, last_bit;
    logic [7:0]               byte_in;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign byte_in   = {shift_q[6:0], sda_lvl};
    assign last_bit  = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = re_dly_q ? mem.mem_rdata : tx_q;
        ptr_d       = ptr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        re_dly_d    = mem_re_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        rd_path_d   = rd_path_q;

        if (start_det) begin
            state_d   = ST_CTRL;
            bit_cnt_d = 3'd0;
            sda_d     = 1'b0;
        end else if (stop_det) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            sda_d   = 1'b0;
        end else if (scl_rise) begin
            if (state_q inside {ST_CTRL, ST_ADDR, ST_WDATA}) begin
                shift_d = byte_in;
            end
            bit_cnt_d = bit_cnt_q + 3'd1;
            case (state_q)
                ST_CTRL: if (last_bit) begin
                    if (byte_in[7:4] != DEV_TYPE) begin
                        state_d = ST_IGNORE;
                        busy_d  = 1'b0;
                    end else begin
                        ptr_d[10:8] = byte_in[3:1];
                        rd_path_d   = byte_in[0];
                        busy_d      = 1'b1;
                        state_d     = ST_CTRL_ACK;
                    end
                end
                ST_CTRL_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (rd_path_q) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        state_d    = ST_RDATA;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_ADDR: if (last_bit) begin
                    ptr_d[7:0] = byte_in;
                    state_d    = ST_ADDR_ACK;
                end
                ST_WDATA: if (last_bit) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q;
                    mem_wdata_d = byte_in;
                    ptr_d       = ptr_q + 1'b1;
                    state_d     = ST_WDATA_ACK;
                end
                ST_ADDR_ACK, ST_WDATA_ACK: begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_WDATA;
                end
                ST_RDATA: if (last_bit) begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = ST_RDATA_ACK;
                end
                ST_RDATA_ACK: begin
                    bit_cnt_d = 3'd0;
                    if (!sda_lvl) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        state_d    = ST_RDATA;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            // SDA only moves here; the next slot's level is set up while SCL is low.
            case (state_q)
                ST_CTRL_ACK, ST_ADDR_ACK, ST_WDATA_ACK: sda_d = 1'b1;
                ST_RDATA: sda_d = ~tx_q[3'd7 - bit_cnt_q];
                default:  sda_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            tx_q        <= 8'd0;
            ptr_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            re_dly_q    <= 1'b0;
            sda_q       <= 1'b0;
            busy_q      <= 1'b0;
            rd_path_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            ptr_q       <= ptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            re_dly_q    <= re_dly_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            rd_path_q   <= rd_path_d;
        end
    end

    assign sda_drive_low = sda_q;
    assign busy          = busy_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_re    = mem_re_q;
endmodule

// File: tb/tb_i2c_eeprom_target.sv
// tb/tb_i2c_eeprom_target.sv - scoreboard bench for i2c_eeprom_target
module tb_i2c_eeprom_target;
    import i2c_target_pkg::*;

    localparam int Q = 8;

    logic clk = 1'b0, reset_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1, preload = 1'b0;
    logic sda_drive_low, busy;
    wire  scl_in = scl_m;
    wire  sda_in = sda_m & ~sda_drive_low;

    i2c_eeprom_target_if mem_if();

    i2c_eeprom_target #(.DEV_TYPE(4'b1010), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_drive_low(sda_drive_low), .busy(busy), .mem(mem_if)
    );

    always #5 clk = ~clk;

    logic [7:0]  init_img [2048];
    logic [7:0]  dut_mem  [2048];
    logic [7:0]  ref_mem  [2048];
    logic [10:0] ref_ptr;
    logic [18:0] exp_we[$];
    logic [10:0] exp_re[$];
    int n_checks = 0, n_pass = 0, sda_low_seen = 0;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 2048; i++) dut_mem[i] <= init_img[i];
        end else begin
            if (mem_if.mem_we) dut_mem[mem_if.mem_addr] <= mem_if.mem_wdata;
            if (mem_if.mem_re) mem_if.mem_rdata <= dut_mem[mem_if.mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset_n && !preload) begin
            if (mem_if.mem_we) begin
                logic [18:0] e;
                check("we_re_exclusive", 32'(mem_if.mem_re), 32'd0);
                check("we_expected", 32'(exp_we.size() != 0), 32'd1);
                if (exp_we.size() != 0) begin
                    e = exp_we.pop_front();
                    check("we_addr", 32'(mem_if.mem_addr), 32'(e[18:8]));
                    check("we_data", 32'(mem_if.mem_wdata), 32'(e[7:0]));
                end
            end
            if (mem_if.mem_re) begin
                check("re_expected", 32'(exp_re.size() != 0), 32'd1);
                if (exp_re.size() != 0) check("re_addr", 32'(mem_if.mem_addr), 32'(exp_re.pop_front()));
            end
            if (sda_drive_low) sda_low_seen++;
        end
    end

    task automatic quarter();
        repeat (Q) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b0; quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; quarter();
        scl_m = 1'b1; quarter();
        sda_m = 1'b1; quarter();
    endtask

    task automatic send_bit(input logic b, output logic s);
        sda_m = b;    quarter();
        scl_m = 1'b1; quarter();
        s = sda_in;   quarter();
        scl_m = 1'b0; quarter();
    endtask

    task automatic put_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(b[i], s);
        send_bit(1'b1, s);
        check(name, 32'(s), 32'(exp_ack));
    endtask

    task automatic get_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            b[i] = s;
        end
        send_bit(ack, s);
    endtask

    // Transaction-level reference model: pointer and memory image per EEPROM rules.
    task automatic ctrl(input logic [7:0] b);
        logic match;
        match = (b[7:4] == 4'b1010);
        if (match) begin
            ref_ptr[10:8] = b[3:1];
            if (b[0]) exp_re.push_back(ref_ptr);
        end
        put_byte(b, !match, "ctrl_ack");
    endtask

    task automatic addr(input logic [7:0] b);
        ref_ptr[7:0] = b;
        put_byte(b, 1'b0, "addr_ack");
    endtask

    task automatic wr(input logic [7:0] b);
        exp_we.push_back({ref_ptr, b});
        ref_mem[ref_ptr] = b;
        ref_ptr = ref_ptr + 11'd1;
        put_byte(b, 1'b0, "wr_ack");
    endtask

    task automatic rd(input logic ack);
        logic [7:0] expv, got;
        expv = ref_mem[ref_ptr];
        ref_ptr = ref_ptr + 11'd1;
        if (!ack) exp_re.push_back(ref_ptr);
        get_byte(ack, got);
        check("rd_data", 32'(got), 32'(expv));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic s;
        logic [2:0] pg;
        logic [7:0] a;
        int n;
        for (int i = 0; i < 2048; i++) init_img[i] = 8'($urandom);
        init_img[11'h123] = 8'h5A;
        init_img[11'h124] = 8'hC3;
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_img[i];
        ref_ptr = '0;
        preload = 1'b1;
        repeat (2) @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("rst_sda", 32'(sda_drive_low), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_if.mem_we), 32'd0);
        check("rst_re", 32'(mem_if.mem_re), 32'd0);
        check("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_if.mem_wdata), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);

        // Basic write of two bytes.
        i2c_start(); ctrl(8'hA0);
        check("busy_after_ctrl", 32'(busy), 32'd1);
        addr(8'h10); wr(8'h55); wr(8'hAA); i2c_stop();
        repeat (4) @(negedge clk);
        check("busy_after_stop", 32'(busy), 32'd0);

        // Random read with repeated START, then a current-address read.
        i2c_start(); ctrl(8'hA2); addr(8'h23);
        i2c_start(); ctrl(8'hA3); rd(1'b0); rd(1'b1); i2c_stop();
        i2c_start(); ctrl(8'hA3); rd(1'b1); i2c_stop();

        // Wrong device type.
        sda_low_seen = 0;
        i2c_start(); ctrl(8'h90);
        check("busy_wrong_type", 32'(busy), 32'd0);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("sda_wrong_type", 32'(sda_low_seen), 32'd0);

        // Pointer wrap at the top of the array, then read across it.
        i2c_start(); ctrl(8'hAE); addr(8'hFF);
        for (int i = 0; i < 3; i++) wr(8'($urandom));
        i2c_stop();
        i2c_start(); ctrl(8'hAE); addr(8'hFF);
        i2c_start(); ctrl(8'hAF); rd(1'b0); rd(1'b0); rd(1'b1); i2c_stop();

        // STOP part way through a data byte.
        a = 8'($urandom);
        i2c_start(); ctrl(8'hA0); addr(a);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), s);
        i2c_stop();
        repeat (4) @(negedge clk);
        check("sda_after_abort", 32'(sda_drive_low), 32'd0);
        check("busy_after_abort", 32'(busy), 32'd0);
        i2c_start(); ctrl(8'hA1); rd(1'b1); i2c_stop();

        // Randomized write bursts read back by random read.
        for (int k = 0; k < 4; k++) begin
            pg = 3'($urandom);
            a  = 8'($urandom);
            n  = $urandom_range(1, 3);
            i2c_start(); ctrl({4'hA, pg, 1'b0}); addr(a);
            for (int i = 0; i < n; i++) wr(8'($urandom));
            i2c_stop();
            i2c_start(); ctrl({4'hA, pg, 1'b0}); addr(a);
            i2c_start(); ctrl({4'hA, pg, 1'b1});
            for (int i = 0; i < n; i++) rd(i == n - 1);
            i2c_stop();
        end

        // Reset while the target drives the control-byte ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7, s);
        check("sda_in_ack_slot", 32'(sda_drive_low), 32'd1);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("sda_async_reset", 32'(sda_drive_low), 32'd0);
        ref_ptr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        i2c_stop();
        check("busy_after_reset", 32'(busy), 32'd0);
        i2c_start(); ctrl(8'hA1); rd(1'b1); i2c_stop();

        repeat (20) @(negedge clk);
        check("we_queue_drained", 32'(exp_we.size()), 32'd0);
        check("re_queue_drained", 32'(exp_re.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_eeprom_target.md
# i2c_eeprom_target

I2C responder emulating a 24xx16-class 2 KiB EEPROM (control byte 1010·A10:A8·R/W, then A7:A0) on the board's I2C bus. The target side of the EEPROM-reading master path: lets the test board exercise `i2c_master` against an in-FPGA EEPROM image, or expose FPGA-held data to an external master. Storage is external: a synchronous byte memory behind a simple single-port interface.

## Interface
- `DEV_TYPE`, 4'b1010: device-type nibble matched against control byte bits 7:4.
- `SYNC_STAGES`, 2: synchronizer depth on `scl_in`/`sda_in`, minimum 2.
- `clk` in 1: system clock, at least 16× SCL frequency (16 MHz vs 400 kHz nominal).
- `reset_n` in 1: reset, asynchronous, active-low.
- `scl_in` in 1: raw SCL pad level.
- `sda_in` in 1: raw SDA pad level.
- `sda_drive_low` out 1: 1 pulls SDA low, 0 releases it (open-drain; pad logic is outside this block).
- `mem_addr` out 11: memory byte address.
- `mem_wdata` out 8: write data.
- `mem_we` out 1: one-cycle write strobe.
- `mem_re` out 1: one-cycle read strobe.
- `mem_rdata` in 8: read data, valid the cycle after `mem_re`.
- `busy` out 1: high from control-byte match to STOP or a non-matching START.

## Operation
- Input path: `SYNC_STAGES` flops plus one history flop per line. Edges are detected on synchronized values only.
- START = SDA falls while SCL high. STOP = SDA rises while SCL high.
  - START/STOP take priority over bit sampling in the same cycle.
  - Both are legal in any state.
  - START (including repeated) goes to CTRL, clears the bit counter, releases SDA.
  - STOP goes to IDLE.
- Bits are sampled on SCL rising edge, MSB first.
- SDA output changes only on SCL falling edge.
- States:
  - IDLE: wait for START.
  - CTRL: shift 8 bits.
    - Bits 7:4 ≠ DEV_TYPE: go to IGNORE, never drive SDA.
    - Match: load ptr[10:8] from bits 3:1, set `busy`.
    - R/W=0 goes to CTRL_ACK(write path); R/W=1 goes to CTRL_ACK(read path).
  - CTRL_ACK: drive 0 for one bit slot.
    - Write path continues to ADDR.
    - Read path continues to RDATA; `mem_re` is issued with ptr on the ACK-slot SCL rising edge.
  - ADDR: 8 bits load ptr[7:0]. ADDR_ACK, then WDATA.
  - WDATA: on the 8th rising edge:
    - `mem_we` pulses with `mem_addr`=ptr and `mem_wdata`=byte.
    - ptr increments next cycle.
    - Then WDATA_ACK (drive 0), then WDATA.
  - RDATA: data byte latched from `mem_rdata` is shifted out on 8 slots; a 0 bit drives low, a 1 bit releases. ptr increments after the byte.
  - RDATA_ACK: release SDA and sample the master bit at SCL rising.
    - 0 (ACK): issue `mem_re` at ptr, go to RDATA.
    - 1 (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START/STOP.
- ptr is 11 bits and wraps 0x7FF→0x000. There is no page wrap.
- ptr persists across transactions, so a current-address read uses the last ptr+1.
- Random read: write control + address, repeated START, read control. The ptr[10:8] bits of the read control byte override the write's.
- STOP or START mid-byte: the partial byte is discarded with no `mem_we`. A byte already written stays written.

## Timing
- Reset values: `sda_drive_low`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, ptr=0, state IDLE.
- Mid-operation reset releases SDA asynchronously.
- Pad-to-detect latency: `SYNC_STAGES`+1 clk.
- SDA update: within `SYNC_STAGES`+2 clk after the physical SCL fall. This meets hold, since no change occurs while SCL is high.
- Read data: `mem_re` at an ACK-slot rising edge; `mem_rdata` is captured 1 clk later, well before the next SCL fall.
- `mem_we`/`mem_re` are exactly 1 clk wide and never asserted together.
- `busy` rises 1 clk after the 8th CTRL bit matches. It falls 1 clk after STOP detect.

## Structure
- Package `i2c_target_pkg`:
  - state enum (IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE);
  - `EEPROM_ADDR_W`=11;
  - default `DEV_TYPE`.
- Sub-module `i2c_line_sync`: synchronizer plus rise/fall detect for one line, instantiated for SCL and SDA.

## Test plan
- Write 0xA0,0x10,0x55,0xAA,STOP: ACK on all 4 bytes; `mem_we` at 0x010=0x55 then 0x011=0xAA; `busy` 0 after STOP.
- Random read (memory pre-filled with 0x123=0x5A, 0x124=0xC3):
  - 0xA2,0x23, rep-START, 0xA3, read 2 bytes with ACK then NACK, STOP.
  - SDA shows 0x5A, 0xC3; `mem_re` at 0x123, 0x124; ptr=0x125.
- Control 0x90 (wrong type): `sda_drive_low` never asserts, `busy` stays 0, no memory strobes.
- Wrap: write 0xAE,0xFF then 3 bytes: addresses 0x7FF, 0x000, 0x001.
- STOP after 5 bits of a data byte: no `mem_we`, state IDLE, SDA released. A following current-address read returns from the unchanged ptr.
- Assert `reset_n` during a driven ACK slot: `sda_drive_low` drops without a clock edge; ptr=0 after release.
